float2int_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision to 32-bit signed integer converter.
- Performs the reverse of the team's combinational integer-to-float converter.
- Rounds toward zero (truncation) and flags precision loss and invalid conversion.
- Sits in the pipelined FPU's conversion path and sustains one operation per cycle under valid/ready flow control.

---
 rtl/f2i_pkg.sv | 38 +++
 rtl/float2int_pipe_if.sv | 18 +
 rtl/f2i_rshift32.sv | 25 ++
 rtl/float2int_pipe.sv | 127 ++++++++++++
 tb/tb_float2int_pipe.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f2i_pkg.sv
// Shared constants, types and helpers for the float-to-int32 converter.
package f2i_pkg;

  localparam int unsigned W_DATA      = 32;
  localparam int unsigned W_EXP       = 8;
  localparam int unsigned W_FRAC      = 23;
  localparam int unsigned W_SH        = 5;

  localparam int unsigned BIAS        = 127;
  localparam int unsigned EXP_INT_MAX = 158;
  localparam logic [31:0] INVALID_VAL_DEFAULT = 32'h8000_0000;

  // fp32 field positions {s, e[7:0], f[22:0]}
  localparam int unsigned FP_SIGN_BIT = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_FRAC_MSB = 22;

  typedef enum logic [2:0] {ZERO, SMALL, NORMAL, EDGE, BIG} f2i_class_t;

  typedef struct packed {
    logic [31:0] d;
    logic        p_lost;
    logic        invalid;
  } f2i_result_t;

  // Range class of a biased exponent relative to int32
  function automatic f2i_class_t f2i_classify(input logic [W_EXP-1:0] e);
    f2i_class_t cls;
    if (e == '0)                          cls = ZERO;
    else if (e < W_EXP'(BIAS))            cls = SMALL;
    else if (e < W_EXP'(EXP_INT_MAX))     cls = NORMAL;
    else if (e == W_EXP'(EXP_INT_MAX))    cls = EDGE;
    else                                  cls = BIG;
    return cls;
  endfunction

endpackage

// File: rtl/float2int_pipe_if.sv
// Valid/ready operand and result bus of the float-to-int converter.
interface float2int_pipe_if;
  import f2i_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [W_DATA-1:0] a;
  logic              out_valid;
  logic              out_ready;
  logic [W_DATA-1:0] d;
  logic              p_lost;
  logic              invalid;

  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, d, p_lost, invalid);
  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, d, p_lost, invalid);
endinterface

// File: rtl/f2i_rshift32.sv
// Combinational 5-level logarithmic right shifter with sticky (OR of lost bits).
module f2i_rshift32
  import f2i_pkg::*;
(
  input  logic [W_DATA-1:0] i_data,
  input  logic [W_SH-1:0]   i_sh,
  output logic [W_DATA-1:0] o_data_c,
  output logic              o_sticky_c
);

  logic [31:0] w_l16, w_l8, w_l4, w_l2;

  assign w_l16    = i_sh[4] ? {16'b0, i_data[31:16]} : i_data;
  assign w_l8     = i_sh[3] ? {8'b0,  w_l16[31:8]}   : w_l16;
  assign w_l4     = i_sh[2] ? {4'b0,  w_l8[31:4]}    : w_l8;
  assign w_l2     = i_sh[1] ? {2'b0,  w_l4[31:2]}    : w_l4;
  assign o_data_c = i_sh[0] ? {1'b0,  w_l2[31:1]}    : w_l2;

  assign o_sticky_c = (i_sh[4] & (|i_data[15:0])) |
                      (i_sh[3] & (|w_l16[7:0]))   |
                      (i_sh[2] & (|w_l8[3:0]))    |
                      (i_sh[1] & (|w_l4[1:0]))    |
                      (i_sh[0] & w_l2[0]);

endmodule

// File: rtl/float2int_pipe.sv
// Three-stage fp32 -> int32 converter (truncating), valid/ready with full-rate backpressure.
module float2int_pipe
  import f2i_pkg::*;
#(
  parameter logic [31:0] INVALID_VAL = INVALID_VAL_DEFAULT
) (
  input  logic             clk,
  input  logic             clrn,
  float2int_pipe_if.slave  bus
);

  logic              w_load1, w_load2, w_load3;
  logic              r_v1, r_v2, r_v3;

  logic              r_s1;
  logic [W_FRAC-1:0] r_f1;
  f2i_class_t        r_cls1;
  logic [W_SH-1:0]   r_sh1;
  logic [W_EXP-1:0]  w_e;

  logic              r_s2, r_fnz2, r_sticky2;
  f2i_class_t        r_cls2;
  logic [31:0]       r_mag2;
  logic [31:0]       w_m1, w_mag1;
  logic              w_sticky1;

  f2i_result_t       w_res2, r_res3;

  // Stage k loads when stage k+1 is empty or draining this cycle
  assign w_load3      = ~r_v3 | bus.out_ready;
  assign w_load2      = ~r_v2 | w_load3;
  assign w_load1      = ~r_v1 | w_load2;
  assign bus.in_ready = w_load1;

  assign w_e  = bus.a[FP_EXP_MSB:FP_EXP_LSB];
  assign w_m1 = {1'b1, r_f1, 8'b0};

  f2i_rshift32 u_shift (
    .i_data     (w_m1),
    .i_sh       (r_sh1),
    .o_data_c   (w_mag1),
    .o_sticky_c (w_sticky1)
  );

  // Stage valid bits
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_load1) r_v1 <= bus.in_valid;
      if (w_load2) r_v2 <= r_v1;
      if (w_load3) r_v3 <= r_v2;
    end
  end

  // S1: split fields, classify exponent, precompute shift for the normal range
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_s1   <= 1'b0;
      r_f1   <= '0;
      r_cls1 <= ZERO;
      r_sh1  <= '0;
    end else if (w_load1 && bus.in_valid) begin
      r_s1   <= bus.a[FP_SIGN_BIT];
      r_f1   <= bus.a[FP_FRAC_MSB:0];
      r_cls1 <= f2i_classify(w_e);
      r_sh1  <= W_SH'(W_EXP'(EXP_INT_MAX) - w_e);
    end
  end

  // S2: align mantissa to the integer point, keep discarded-bit summary
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_s2      <= 1'b0;
      r_fnz2    <= 1'b0;
      r_sticky2 <= 1'b0;
      r_cls2    <= ZERO;
      r_mag2    <= '0;
    end else if (w_load2 && r_v1) begin
      r_s2      <= r_s1;
      r_fnz2    <= |r_f1;
      r_sticky2 <= w_sticky1;
      r_cls2    <= r_cls1;
      r_mag2    <= w_mag1;
    end
  end

  // S3 next value: apply sign, resolve per-class result and flags
  always_comb begin
    w_res2 = '0;
    case (r_cls2)
      ZERO:   w_res2.p_lost = r_fnz2;
      SMALL:  w_res2.p_lost = 1'b1;
      NORMAL: begin
        w_res2.d      = r_s2 ? (~r_mag2 + 32'd1) : r_mag2;
        w_res2.p_lost = r_sticky2;
      end
      EDGE: begin
        // only exactly -2^31 is representable at this exponent
        if (r_s2 && !r_fnz2) w_res2.d       = 32'h8000_0000;
        else                 w_res2.invalid = 1'b1;
      end
      default: w_res2.invalid = 1'b1;
    endcase
    if (w_res2.invalid) begin
      w_res2.d      = INVALID_VAL;
      w_res2.p_lost = 1'b0;
    end
  end

  // S3 result register; changes only when a new result enters
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_res3 <= '0;
    end else if (w_load3 && r_v2) begin
      r_res3 <= w_res2;
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.d         = r_res3.d;
  assign bus.p_lost    = r_res3.p_lost;
  assign bus.invalid   = r_res3.invalid;

endmodule

// File: tb/tb_float2int_pipe.sv
// Bench for float2int_pipe: vector table, hand-written flow/reset sequences, random vs. model.
module tb_float2int_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        p;
    logic        inv;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    exp_t        e;
  } vec_t;

  logic clk;
  logic clrn;
  float2int_pipe_if bus ();

  float2int_pipe dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;
  int   n_stall = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  vec_t vq[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_p, prev_inv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic p, input logic inv);
    exp_t r;
    r.d = d; r.p = p; r.inv = inv;
    return r;
  endfunction

  // Reference: exact value (-1)^s * mant * 2^exp2, truncated toward zero, range-checked
  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    int     e, exp2, nsh;
    longint mant, mag, val;
    bit     lost;
    r = mk(32'h8000_0000, 1'b0, 1'b1);
    e = int'(x[30:23]);
    if (e == 255) return r;
    if (e == 0) begin
      mant = longint'(x[22:0]);
      exp2 = -149;
    end else begin
      mant = (64'sd1 <<< 23) + longint'(x[22:0]);
      exp2 = e - 150;
    end
    if (exp2 > 16) return r;
    if (exp2 >= 0) begin
      mag  = mant <<< exp2;
      lost = 1'b0;
    end else begin
      nsh = -exp2;
      if (nsh >= 40) begin
        mag  = 0;
        lost = (mant != 0);
      end else begin
        mag  = mant >>> nsh;
        lost = ((mant & ((64'sd1 <<< nsh) - 64'sd1)) != 0);
      end
    end
    val = x[31] ? -mag : mag;
    if (val > 64'sd2147483647 || val < -64'sd2147483648) return r;
    return mk(32'(val), lost, 1'b0);
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'd158;
      3:       e = 8'($urandom_range(159, 254));
      4:       e = 8'($urandom_range(1, 126));
      default: e = 8'($urandom_range(127, 157));
    endcase
    f = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Monitor: occupancy-based in_ready check, stall hold check, in-order scoreboard
  always @(negedge clk) begin
    exp_t ex;
    if (clrn) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!(exp_q.size() == 3 && !bus.out_ready)));
      if (!bus.in_ready) n_stall++;
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_d", bus.d, prev_d);
        chk("hold_flags", 32'({bus.p_lost, bus.invalid}), 32'({prev_p, prev_inv}));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.d;
      prev_p     = bus.p_lost;
      prev_inv   = bus.invalid;
      if (bus.out_valid && bus.out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", bus.d, 32'hxxxx_xxxx);
        end else begin
          ex = exp_q.pop_front();
          chk("d", bus.d, ex.d);
          chk("p_lost", 32'(bus.p_lost), 32'(ex.p));
          chk("invalid", 32'(bus.invalid), 32'(ex.inv));
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [31:0] val, input exp_t e);
    bit ok;
    ok = 1'b0;
    bus.a        = val;
    cur_exp      = e;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pops0, stall0;
    logic [31:0] x;
    logic [31:0] stream_vals [5];
    bit   done;

    stream_vals[0] = 32'h3F80_0000; stream_vals[1] = 32'h4000_0000;
    stream_vals[2] = 32'h4040_0000; stream_vals[3] = 32'h4080_0000;
    stream_vals[4] = 32'h40A0_0000;

    vq.push_back('{32'h3F80_0000, mk(32'h0000_0001, 1'b0, 1'b0)});
    vq.push_back('{32'hBFC0_0000, mk(32'hFFFF_FFFF, 1'b1, 1'b0)});
    vq.push_back('{32'h3F00_0000, mk(32'h0000_0000, 1'b1, 1'b0)});
    vq.push_back('{32'hBF00_0000, mk(32'h0000_0000, 1'b1, 1'b0)});
    vq.push_back('{32'hCF00_0000, mk(32'h8000_0000, 1'b0, 1'b0)});
    vq.push_back('{32'h4F00_0000, mk(32'h8000_0000, 1'b0, 1'b1)});
    vq.push_back('{32'hCF00_0001, mk(32'h8000_0000, 1'b0, 1'b1)});
    vq.push_back('{32'h7FC0_0000, mk(32'h8000_0000, 1'b0, 1'b1)});
    vq.push_back('{32'hFF80_0000, mk(32'h8000_0000, 1'b0, 1'b1)});
    vq.push_back('{32'h4EFF_FFFF, mk(32'h7FFF_FF80, 1'b0, 1'b0)});
    vq.push_back('{32'h0000_0001, mk(32'h0000_0000, 1'b1, 1'b0)});
    vq.push_back('{32'h0000_0000, mk(32'h0000_0000, 1'b0, 1'b0)});
    vq.push_back('{32'h8000_0000, mk(32'h0000_0000, 1'b0, 1'b0)});
    vq.push_back('{32'h4120_0000, mk(32'h0000_000A, 1'b0, 1'b0)});

    clrn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d", bus.d, 32'd0);
    chk("rst_flags", 32'({bus.p_lost, bus.invalid}), 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Latency: result visible exactly after the 3rd edge following acceptance
    send(32'h3F80_0000, mk(32'd1, 1'b0, 1'b0));
    @(negedge clk); chk("lat_edge1", 32'(bus.out_valid), 32'd0);
    @(negedge clk); chk("lat_edge2", 32'(bus.out_valid), 32'd0);
    @(negedge clk); chk("lat_edge3", 32'(bus.out_valid), 32'd1);
    drain();

    // Vector table, issued back to back
    foreach (vq[i]) send(vq[i].a, vq[i].e);
    drain();

    // Stream 1..5 with a two-cycle consumer stall once the pipe is full
    pops0  = n_pops;
    stall0 = n_stall;
    fork
      begin
        for (int i = 0; i < 5; i++) send(stream_vals[i], mk(32'(i + 1), 1'b0, 1'b0));
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 32'(n_pops - pops0), 32'd5);
    chk("stream_in_ready_dropped", 32'(n_stall > stall0), 32'd1);

    // Reset with three operations in flight
    send(32'h42C8_0000, mk(32'd100, 1'b0, 1'b0));
    send(32'h4348_0000, mk(32'd200, 1'b0, 1'b0));
    send(32'h4396_0000, mk(32'd300, 1'b0, 1'b0));
    clrn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_d", bus.d, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    clrn  = 1'b1;
    pops0 = n_pops;
    send(32'h4120_0000, mk(32'd10, 1'b0, 1'b0));
    drain();
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_result_count", 32'(n_pops - pops0), 32'd1);

    // Random operands, random gaps and random consumer backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          x = rand_float();
          send(x, model(x));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
